// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
//   - Tuse/Tnew encodings (Tuse 3 = operand unused, never hazards).
//   - Default mult/div busy lengths.
//   - reg_hazard(): one operand's RAW check against the E and M producers.
package pipe_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    typedef enum logic {MdIdle, MdBusy} md_state_e;

    // Producer result not ready before the consumer needs it. $0 is hardwired,
    // and Tuse 3 can never be exceeded because Tnew is at most 2.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_wa) && (e_tnew > tuse)) ||
                ((src == m_wa) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the multiply/divide unit.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : mult/div start pulse from E (loads the counter, even when busy)
//   is_div     : 1 = divide length, 0 = multiply length
//   busy       : unit busy, including the start cycle itself
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    md_state_e        state;

    // The count is the state; IDLE is simply cnt == 0.
    assign state = (cnt_q != '0) ? MdBusy : MdIdle;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
        end else if (state == MdBusy) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        busy = start | (state == MdBusy);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller beside the D stage.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   d_rs/d_rt             : D-stage source registers
//   d_tuse_rs/d_tuse_rt   : cycles until each source is needed (3 = unused)
//   d_md_use              : D instruction touches the mult/div unit or HI/LO
//   e_wa/e_tnew           : E-stage destination and cycles until its result
//   m_wa/m_tnew           : M-stage destination and cycles until its result
//   e_md_start/e_md_div   : mult/div start pulse in E and its kind
//   pc_we/fd_we           : PC and F->D register write enables (low = hold)
//   de_clr                : D->E synchronous clear (bubble)
//   md_busy               : mult/div unit busy
//   stall_cnt             : saturating count of stall cycles since reset
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_md_use,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        pc_we,
    output logic        fd_we,
    output logic        de_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic        hz_rs;
    logic        hz_rt;
    logic        hz_md;
    logic        stall;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_div),
        .busy   (md_busy)
    );

    always_comb begin
        hz_rs  = reg_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
        hz_rt  = reg_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        hz_md  = d_md_use & md_busy;
        // Never hold the front end while in reset.
        stall  = (hz_rs | hz_rt | hz_md) & ~reset;
        pc_we  = ~stall;
        fd_we  = ~stall;
        de_clr = stall;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    typedef struct {
        logic       reset;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       md_use;
        logic [4:0] ewa;
        logic [1:0] etnew;
        logic [4:0] mwa;
        logic [1:0] mtnew;
        logic       start;
        logic       is_div;
        logic       do_force;
    } stim_t;

    typedef struct {
        logic        pc_we;
        logic        fd_we;
        logic        de_clr;
        logic        md_busy;
        logic [31:0] stall_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_md_use, e_md_start, e_md_div;
    logic        pc_we, fd_we, de_clr, md_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    // Reference model state: absolute cycle number and the last cycle the
    // unit is still busy (-1 = not busy).
    longint      cyc      = 0;
    longint      busy_end = -1;
    logic [31:0] m_cnt    = 32'd0;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md_use   (d_md_use),
        .e_wa       (e_wa),
        .e_tnew     (e_tnew),
        .m_wa       (m_wa),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .pc_we      (pc_we),
        .fd_we      (fd_we),
        .de_clr     (de_clr),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.reset = 1'b0; s.rs = 5'd0; s.rt = 5'd0;
        s.tuse_rs = 2'd3; s.tuse_rt = 2'd3; s.md_use = 1'b0;
        s.ewa = 5'd0; s.etnew = 2'd0; s.mwa = 5'd0; s.mtnew = 2'd0;
        s.start = 1'b0; s.is_div = 1'b0; s.do_force = 1'b0;
        return s;
    endfunction

    function automatic logic needs_stall(input logic [4:0] src, input logic [1:0] tuse,
                                         input stim_t s);
        if (src == 5'd0) return 1'b0;
        if (src == s.ewa && int'(s.etnew) > int'(tuse)) return 1'b1;
        if (src == s.mwa && int'(s.mtnew) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive at negedge, predict, push, then advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        logic busy, stl;
        @(negedge clk);
        reset = s.reset; d_rs = s.rs; d_rt = s.rt;
        d_tuse_rs = s.tuse_rs; d_tuse_rt = s.tuse_rt; d_md_use = s.md_use;
        e_wa = s.ewa; e_tnew = s.etnew; m_wa = s.mwa; m_tnew = s.mtnew;
        e_md_start = s.start; e_md_div = s.is_div;
        if (s.do_force) begin
            force dut.stall_cnt_q = 32'hFFFF_FFFE;
            #1;
            release dut.stall_cnt_q;
            m_cnt = 32'hFFFF_FFFE;
        end
        busy = s.start || (cyc <= busy_end);
        stl  = (needs_stall(s.rs, s.tuse_rs, s) || needs_stall(s.rt, s.tuse_rt, s) ||
                (s.md_use && busy)) && !s.reset;
        e.pc_we = !stl; e.fd_we = !stl; e.de_clr = stl;
        e.md_busy = busy; e.stall_cnt = m_cnt;
        sb_q.push_back(e);
        if (s.reset) begin
            m_cnt = 32'd0;
            busy_end = -1;
        end else begin
            if (stl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (s.start) busy_end = cyc + (s.is_div ? 10 : 5);
        end
        cyc++;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_we",     {31'd0, pc_we},   {31'd0, e.pc_we});
                chk("fd_we",     {31'd0, fd_we},   {31'd0, e.fd_we});
                chk("de_clr",    {31'd0, de_clr},  {31'd0, e.de_clr});
                chk("md_busy",   {31'd0, md_busy}, {31'd0, e.md_busy});
                chk("stall_cnt", stall_cnt,        e.stall_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        s = idle();
        reset = 1'b1; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_md_use = 0;
        e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0; e_md_start = 0; e_md_div = 0;
        repeat (2) @(posedge clk);

        // Reset state is checked by the scoreboard.
        s = idle(); s.reset = 1'b1; s.md_use = 1'b1; s.rs = 5'd5; s.tuse_rs = 2'd0;
        s.ewa = 5'd5; s.etnew = 2'd1;
        step(s);
        s.reset = 1'b0;

        // RAW with E producer, then Tuse that is late enough.
        s.md_use = 1'b0;
        step(s);
        s.tuse_rs = 2'd1; step(s);
        // $0 and unused operand.
        s = idle(); s.ewa = 5'd0; s.etnew = 2'd2; step(s);
        s = idle(); s.rt = 5'd7; s.tuse_rt = 2'd3; s.mwa = 5'd7; s.mtnew = 2'd2; step(s);
        s.tuse_rt = 2'd1; step(s);

        // Multiply timing from a fresh reset.
        s = idle(); s.reset = 1'b1; step(s);
        s = idle(); s.md_use = 1'b1; s.start = 1'b1; step(s);
        s.start = 1'b0;
        repeat (5) step(s);
        step(s);
        #2;
        chk("mult_release_pc_we", {31'd0, pc_we}, 32'd1);
        chk("mult_stall_cnt", stall_cnt, 32'd6);

        // Divide then restart with multiply at t=3.
        s = idle(); s.start = 1'b1; s.is_div = 1'b1; step(s);
        s = idle(); repeat (2) step(s);
        s.start = 1'b1; step(s);
        s.start = 1'b0; repeat (5) step(s);
        step(s);
        #2;
        chk("restart_busy_low_t9", {31'd0, md_busy}, 32'd0);

        // Reset mid-busy.
        s = idle(); s.start = 1'b1; s.is_div = 1'b1; step(s);
        s = idle(); s.md_use = 1'b1; repeat (3) step(s);
        s.reset = 1'b1; step(s);
        #2;
        chk("reset_pc_we", {31'd0, pc_we}, 32'd1);
        chk("reset_de_clr", {31'd0, de_clr}, 32'd0);
        s.reset = 1'b0; step(s);
        #2;
        chk("post_reset_busy", {31'd0, md_busy}, 32'd0);
        chk("post_reset_cnt", stall_cnt, 32'd0);

        // Saturation.
        s = idle(); s.rs = 5'd3; s.tuse_rs = 2'd0; s.mwa = 5'd3; s.mtnew = 2'd1;
        s.do_force = 1'b1; step(s);
        s.do_force = 1'b0; repeat (2) step(s);
        s = idle(); step(s);
        #2;
        chk("saturate", stall_cnt, 32'hFFFF_FFFF);
        s.reset = 1'b1; step(s);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            s.reset    = ($urandom_range(0, 49) == 0);
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.tuse_rs  = 2'($urandom_range(0, 3));
            s.tuse_rt  = 2'($urandom_range(0, 3));
            s.md_use   = ($urandom_range(0, 9) < 3);
            s.ewa      = 5'($urandom_range(0, 3));
            s.etnew    = 2'($urandom_range(0, 2));
            s.mwa      = 5'($urandom_range(0, 3));
            s.mtnew    = 2'($urandom_range(0, 2));
            s.start    = ($urandom_range(0, 9) == 0);
            s.is_div   = 1'($urandom_range(0, 1));
            s.do_force = 1'b0;
            step(s);
        end

        @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Stall and flush controller for the 5-stage pipeline: decides every cycle whether the F→D pipeline register and PC hold, and whether the D→E register receives a bubble. It combines Tuse/Tnew data-hazard detection with a HI/LO busy timer for the multiply/divide unit. It sits beside the D stage and drives the PC write enable, the F→D register `WE`, and the D→E register synchronous clear.

## Interface
- `MULT_CYCLES`, 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, 10: busy cycles after a div/divu start.
- `CNT_W`, 4: busy counter width; must hold `max(MULT_CYCLES, DIV_CYCLES)`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `d_rs` in 5: D-stage rs address.
- `d_rt` in 5: D-stage rt address.
- `d_tuse_rs` in 2: cycles until rs is needed; 3 means unused.
- `d_tuse_rt` in 2: cycles until rt is needed; 3 means unused.
- `d_md_use` in 1: D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `e_wa` in 5: E-stage destination register.
- `e_tnew` in 2: cycles until the E-stage result is ready.
- `m_wa` in 5: M-stage destination register.
- `m_tnew` in 2: cycles until the M-stage result is ready.
- `e_md_start` in 1: E-stage instruction is mult/multu/div/divu (1-cycle pulse).
- `e_md_div` in 1: qualifies `e_md_start`; 1 = divide, 0 = multiply.
- `pc_we` out 1: PC write enable.
- `fd_we` out 1: F→D register write enable.
- `de_clr` out 1: D→E register synchronous clear (bubble).
- `md_busy` out 1: mult/div unit busy, including the start cycle.
- `stall_cnt` out 32: saturating count of stall cycles since reset.

## Operation
- Register hazard on rs, combinational: `d_rs != 0` and either
  - `d_rs == e_wa` and `e_tnew > d_tuse_rs`, or
  - `d_rs == m_wa` and `m_tnew > d_tuse_rs`.
- Register hazard on rt: same rule using `d_rt` and `d_tuse_rt`.
- `$0` never hazards. Tuse = 3 never hazards, because Tnew ≤ 2.
- md hazard: `d_md_use & md_busy`.
- `stall = (hz_rs | hz_rt | hz_md) & ~reset`.
- Outputs: `pc_we = fd_we = ~stall`; `de_clr = stall`.
- Busy timer is a down-counter `cnt` with two states, IDLE (`cnt==0`) and BUSY (`cnt!=0`):
  - `e_md_start` loads `DIV_CYCLES` if `e_md_div`, else `MULT_CYCLES`. This takes priority over decrement and applies even in BUSY.
  - Otherwise `cnt` decrements when nonzero.
  - `md_busy = e_md_start | (cnt != 0)`.
- `stall_cnt` increments on each cycle with `stall = 1`. It saturates at `32'hFFFF_FFFF`.

## Timing
- Reset values: `cnt = 0`, `stall_cnt = 0`, `md_busy = 0`.
- While `reset` is high: `pc_we = 1`, `fd_we = 1`, `de_clr = 0`.
- Reset asserted mid-busy: `cnt` is 0 on the next cycle and the busy period is abandoned.
- Hazard outputs are combinational, with zero latency from inputs.
- `e_md_start` in cycle t: `md_busy` is high in cycles t .. t+N, i.e. N+1 cycles, where N is the loaded value. It falls in cycle t+N+1.
- `e_md_start` and `d_md_use` in the same cycle: stall that cycle.
- While stalled, the D-stage instruction is held. The bubble inserted into E carries `e_wa = 0` and `e_tnew = 0`, so the stall resolves once the producing instruction advances.
- A restart while BUSY reloads the full count. Legal code cannot produce this, because D stalls md instructions while busy; the reload behaviour is still required.

## Structure
- Shared pipeline package `pipe_pkg` holds:
  - Tuse/Tnew encodings, including the constant `TUSE_NONE = 2'd3`;
  - `MULT_CYCLES` and `DIV_CYCLES` defaults.
- One sub-module, `md_busy_timer`, contains:
  - the counter, load/decrement logic and the `md_busy` output;
  - ports `clk`, `reset`, `start`, `is_div`, `busy`.
- Hazard comparators and the stall counter live in the top module.

## Test plan
- RAW, E-stage producer: `d_rs=5`, `d_tuse_rs=0`, `e_wa=5`, `e_tnew=1` → `pc_we=0`, `fd_we=0`, `de_clr=1`. Same inputs with `d_tuse_rs=1` → no stall.
- `$0` and unused operand: `d_rs=0`, `e_wa=0`, `e_tnew=2` → no stall. `d_rt=7`, `d_tuse_rt=3`, `m_wa=7`, `m_tnew=2` → no stall.
- Multiply timing: `e_md_start=1`, `e_md_div=0` at t=0, `d_md_use=1` held → stall for cycles 0..5, `pc_we=1` at cycle 6, `stall_cnt=6`.
- Divide restart: div start at t=0, mult start at t=3 → `md_busy` high through t=8, low at t=9.
- Reset mid-busy: div start at t=0, `reset` at t=4 → `md_busy=0` and `stall_cnt=0` from t=5. During t=4, `pc_we=1` and `de_clr=0`.
- Saturation: force `stall_cnt` to `32'hFFFF_FFFE`, apply 3 stall cycles → `stall_cnt` holds at `32'hFFFF_FFFF`.
